// File: rtl/heartbeat_monitor.sv
// heartbeat_monitor: receive-side checker for a periodic one-cycle pad heartbeat.
// Synchronises hb_in, measures the beat-to-beat interval, and locks after LOCK_CNT
// in-window intervals. Flags early beats and missing (late) beats.
// Optional statistics counters are enabled by defining HEARTBEAT_MON_STATS_EN.
module heartbeat_monitor #(
  parameter int unsigned N        = 8,
  parameter int unsigned TOL      = 4,
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned CW       = 16
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          hb_in,
  input  logic          clear,
  output logic [1:0]    state,
  output logic          alive,
  output logic          locked,
  output logic          early_err,
  output logic          late_err,
  output logic [N:0]    period,
  output logic [CW-1:0] beat_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam int unsigned GW  = N + 1;
  localparam int unsigned IW  = N + 2;
  localparam int unsigned P   = 1 << N;
  localparam int unsigned GCW = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);

  localparam logic [IW-1:0]  WIN_LO  = IW'(P - TOL);
  localparam logic [IW-1:0]  WIN_HI  = IW'(P + TOL);
  localparam logic [GW-1:0]  GAP_TO  = GW'(P + TOL);
  localparam logic [GW-1:0]  GAP_MAX = '1;
  localparam logic [GCW-1:0] GOOD_LAST = GCW'(LOCK_CNT - 1);
  localparam logic [GCW-1:0] GOOD_FULL = GCW'(LOCK_CNT);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACQ    = 2'b01,
    ST_LOCKED = 2'b10,
    ST_LOST   = 2'b11
  } state_t;

  logic           r_sync1;
  logic           r_sync2;
  logic           r_edge;
  logic [GW-1:0]  r_gap;
  logic [GCW-1:0] r_good_cnt;
  state_t         r_state;
  logic [GW-1:0]  r_period;
  logic           r_early;
  logic           r_late;
  logic           r_alive;
  logic           r_locked;

  logic           w_beat;
  logic [IW-1:0]  w_interval;
  logic           w_is_early;
  logic           w_is_over;
  logic           w_timeout;
  state_t         w_state_nxt;
  logic [GCW-1:0] w_good_nxt;
  logic [GW-1:0]  w_gap_nxt;
  logic [GW-1:0]  w_period_nxt;
  logic           w_early_nxt;
  logic           w_late_nxt;

  // Two-flop synchroniser plus edge register; beat is the rising edge of the synced pad.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_edge  <= 1'b0;
    end else begin
      r_sync1 <= hb_in;
      r_sync2 <= r_sync1;
      r_edge  <= r_sync2;
    end
  end

  assign w_beat     = r_sync2 & ~r_edge;
  assign w_interval = {1'b0, r_gap} + IW'(1);
  assign w_is_early = (w_interval < WIN_LO);
  assign w_is_over  = (w_interval > WIN_HI);
  assign w_timeout  = !w_beat && (r_gap == GAP_TO);

  // Next-state, interval bookkeeping and error pulses; clear overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good_cnt;
    w_period_nxt = r_period;
    w_early_nxt  = 1'b0;
    w_late_nxt   = 1'b0;
    if (w_beat) begin
      w_gap_nxt = '0;
    end else if (r_gap == GAP_MAX) begin
      w_gap_nxt = r_gap;
    end else begin
      w_gap_nxt = r_gap + GW'(1);
    end

    if (clear) begin
      w_state_nxt  = ST_IDLE;
      w_good_nxt   = '0;
      w_period_nxt = '0;
      w_gap_nxt    = '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_LOST: begin
          if (w_beat) begin
            w_state_nxt = ST_ACQ;
            w_good_nxt  = '0;
          end
        end
        ST_ACQ, ST_LOCKED: begin
          if (w_beat) begin
            w_period_nxt = w_interval[GW-1:0];
            if (w_is_early) begin
              w_early_nxt = 1'b1;
              w_good_nxt  = '0;
              w_state_nxt = ST_ACQ;
            end else if (w_is_over) begin
              // Beat landed on the timeout cycle itself: late, restart acquisition.
              w_late_nxt  = 1'b1;
              w_good_nxt  = '0;
              w_state_nxt = ST_ACQ;
            end else if (r_state == ST_ACQ) begin
              if (r_good_cnt >= GOOD_LAST) begin
                w_good_nxt  = GOOD_FULL;
                w_state_nxt = ST_LOCKED;
              end else begin
                w_good_nxt = r_good_cnt + GCW'(1);
              end
            end
          end else if (w_timeout) begin
            w_late_nxt  = 1'b1;
            w_state_nxt = ST_LOST;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state    <= ST_IDLE;
      r_gap      <= '0;
      r_good_cnt <= '0;
      r_period   <= '0;
      r_early    <= 1'b0;
      r_late     <= 1'b0;
      r_alive    <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_gap      <= w_gap_nxt;
      r_good_cnt <= w_good_nxt;
      r_period   <= w_period_nxt;
      r_early    <= w_early_nxt;
      r_late     <= w_late_nxt;
      r_alive    <= (w_state_nxt == ST_ACQ) || (w_state_nxt == ST_LOCKED);
      r_locked   <= (w_state_nxt == ST_LOCKED);
    end
  end

  assign state     = r_state;
  assign alive     = r_alive;
  assign locked    = r_locked;
  assign early_err = r_early;
  assign late_err  = r_late;
  assign period    = r_period;

`ifdef HEARTBEAT_MON_STATS_EN
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0] r_beat_cnt;
  logic [CW-1:0] r_err_cnt;

  // Saturating beat and error event counters.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
    end else if (clear) begin
      r_beat_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_beat && (r_beat_cnt != CNT_MAX)) begin
        r_beat_cnt <= r_beat_cnt + CW'(1);
      end
      if ((w_early_nxt || w_late_nxt) && (r_err_cnt != CNT_MAX)) begin
        r_err_cnt <= r_err_cnt + CW'(1);
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
  assign err_cnt  = r_err_cnt;
`else
  assign beat_cnt = '0;
  assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_heartbeat_monitor.sv
// Testbench for heartbeat_monitor (N=4 -> P=16, TOL=2, LOCK_CNT=3, CW=4).
// Expected outputs are queued when a beat is driven and compared at the cycle the
// registered result appears (hb_in rise + 3 clk).
module tb_heartbeat_monitor;

  localparam int CWT = 4;
  localparam int CMAX = 15;
  localparam logic [1:0] S_IDLE = 2'b00, S_ACQ = 2'b01, S_LOCK = 2'b10, S_LOST = 2'b11;
  localparam int SEL_STATE = 0, SEL_PERIOD = 1, SEL_EARLY = 2, SEL_LATE = 3,
                 SEL_BEATS = 4, SEL_ERRS = 5, SEL_ALIVE = 6, SEL_LOCKED = 7;

  logic clk = 1'b0;
  logic nreset;
  logic hb_in;
  logic clear;
  logic [1:0] state;
  logic alive, locked, early_err, late_err;
  logic [4:0] period;
  logic [CWT-1:0] beat_cnt, err_cnt;

  heartbeat_monitor #(.N(4), .TOL(2), .LOCK_CNT(3), .CW(CWT)) dut (
    .clk(clk), .nreset(nreset), .hb_in(hb_in), .clear(clear),
    .state(state), .alive(alive), .locked(locked),
    .early_err(early_err), .late_err(late_err), .period(period),
    .beat_cnt(beat_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    int          sel;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int last_rise = 0;
  int n_total = 0;
  int n_bad = 0;
  int n_beats = 0;
  int n_errs = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] pick(input int sel);
    case (sel)
      SEL_STATE:  return 32'(state);
      SEL_PERIOD: return 32'(period);
      SEL_EARLY:  return 32'(early_err);
      SEL_LATE:   return 32'(late_err);
      SEL_BEATS:  return 32'(beat_cnt);
      SEL_ERRS:   return 32'(err_cnt);
      SEL_ALIVE:  return 32'(alive);
      default:    return 32'(locked);
    endcase
  endfunction

  function automatic int exp_stat(input int v);
`ifdef HEARTBEAT_MON_STATS_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  // Scoreboard monitor: compare every entry that falls due this cycle.
  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        chk(sb[i].tag, pick(sb[i].sel), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic push(input int due, input int sel, input int exp, input string tag);
    exp_t e;
    e.due = due; e.sel = sel; e.exp = 32'(exp); e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : CMAX;
  endfunction

  task automatic exp_beat(input int c, input logic [1:0] st, input int per,
                          input bit e, input bit l, input string tg);
    n_beats = sat_inc(n_beats);
    if (e || l) n_errs = sat_inc(n_errs);
    push(c + 3, SEL_STATE,  int'(st), {tg, "_state"});
    push(c + 3, SEL_PERIOD, per, {tg, "_period"});
    push(c + 3, SEL_EARLY,  int'(e), {tg, "_early"});
    push(c + 3, SEL_LATE,   int'(l), {tg, "_late"});
    push(c + 3, SEL_ALIVE,  (st == S_ACQ || st == S_LOCK) ? 1 : 0, {tg, "_alive"});
    push(c + 3, SEL_LOCKED, (st == S_LOCK) ? 1 : 0, {tg, "_locked"});
    push(c + 3, SEL_BEATS,  exp_stat(n_beats), {tg, "_beats"});
    push(c + 3, SEL_ERRS,   exp_stat(n_errs), {tg, "_errs"});
    push(c + 4, SEL_EARLY,  0, {tg, "_early_off"});
    push(c + 4, SEL_LATE,   0, {tg, "_late_off"});
  endtask

  task automatic send_beat(input int spacing, input logic [1:0] st, input int per,
                           input bit e, input bit l, input string tg);
    int c;
    c = last_rise + spacing;
    wait_until(c);
    exp_beat(c, st, per, e, l, tg);
    hb_in = 1'b1;
    wait_until(c + 1);
    hb_in = 1'b0;
    last_rise = c;
  endtask

  task automatic check_all_zero(input string tg);
    chk({tg, "_state"},  32'(state), 0);
    chk({tg, "_alive"},  32'(alive), 0);
    chk({tg, "_locked"}, 32'(locked), 0);
    chk({tg, "_early"},  32'(early_err), 0);
    chk({tg, "_late"},   32'(late_err), 0);
    chk({tg, "_period"}, 32'(period), 0);
    chk({tg, "_beats"},  32'(beat_cnt), 0);
    chk({tg, "_errs"},   32'(err_cnt), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d expected < 10000", cyc);
    $fatal(1);
  end

  initial begin
    int c;
    int r;
    nreset = 1'b0;
    hb_in  = 1'b0;
    clear  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    nreset = 1'b1;
    last_rise = cyc;

    // Acquire and lock on a clean 16-cycle beat.
    send_beat(10, S_ACQ,  0,  0, 0, "b1");
    send_beat(16, S_ACQ,  16, 0, 0, "b2");
    send_beat(16, S_ACQ,  16, 0, 0, "b3");
    send_beat(16, S_LOCK, 16, 0, 0, "b4");

    // Window edges, early beats in LOCKED and ACQ, relock.
    send_beat(14, S_LOCK, 14, 0, 0, "win14");
    send_beat(18, S_LOCK, 18, 0, 0, "win18");
    send_beat(13, S_ACQ,  13, 1, 0, "early13");
    send_beat(10, S_ACQ,  10, 1, 0, "early_acq");
    send_beat(16, S_ACQ,  16, 0, 0, "re1");
    send_beat(16, S_ACQ,  16, 0, 0, "re2");
    send_beat(16, S_LOCK, 16, 0, 0, "re3");

    // Missing beats: single late pulse 19 clk after the last beat, then LOST.
    n_errs = sat_inc(n_errs);
    push(last_rise + 21, SEL_LATE,   0, "to_pre");
    push(last_rise + 22, SEL_LATE,   1, "to_late");
    push(last_rise + 22, SEL_STATE,  int'(S_LOST), "to_state");
    push(last_rise + 22, SEL_ALIVE,  0, "to_alive");
    push(last_rise + 22, SEL_LOCKED, 0, "to_locked");
    push(last_rise + 22, SEL_PERIOD, 16, "to_period");
    push(last_rise + 22, SEL_ERRS,   exp_stat(n_errs), "to_errs");
    push(last_rise + 23, SEL_LATE,   0, "to_once");
    push(last_rise + 23, SEL_STATE,  int'(S_LOST), "to_lost");
    push(last_rise + 40, SEL_LATE,   0, "lost_quiet");
    send_beat(45, S_ACQ,  16, 0, 0, "lost_b");
    send_beat(16, S_ACQ,  16, 0, 0, "lk1");
    send_beat(16, S_ACQ,  16, 0, 0, "lk2");
    send_beat(16, S_LOCK, 16, 0, 0, "lk3");
    send_beat(16, S_LOCK, 16, 0, 0, "sat1");
    send_beat(16, S_LOCK, 16, 0, 0, "sat2");

    // Clear in the same cycle as an (early) beat: back to IDLE, nothing flagged.
    c = last_rise + 13;
    wait_until(c);
    hb_in = 1'b1;
    wait_until(c + 1);
    hb_in = 1'b0;
    wait_until(c + 2);
    clear = 1'b1;
    n_beats = 0;
    n_errs = 0;
    push(c + 3, SEL_STATE,  int'(S_IDLE), "clr_state");
    push(c + 3, SEL_PERIOD, 0, "clr_period");
    push(c + 3, SEL_EARLY,  0, "clr_early");
    push(c + 3, SEL_LATE,   0, "clr_late");
    push(c + 3, SEL_ALIVE,  0, "clr_alive");
    push(c + 3, SEL_LOCKED, 0, "clr_locked");
    push(c + 3, SEL_BEATS,  0, "clr_beats");
    push(c + 3, SEL_ERRS,   0, "clr_errs");
    push(c + 4, SEL_EARLY,  0, "clr_early_off");
    push(c + 28, SEL_STATE, int'(S_IDLE), "idle_no_to_state");
    push(c + 28, SEL_LATE,  0, "idle_no_to_late");
    wait_until(c + 3);
    clear = 1'b0;
    last_rise = c;
    send_beat(40, S_ACQ,  0,  0, 0, "ic1");
    send_beat(16, S_ACQ,  16, 0, 0, "ic2");
    send_beat(16, S_ACQ,  16, 0, 0, "ic3");
    send_beat(16, S_LOCK, 16, 0, 0, "ic4");
    wait_until(last_rise + 6);
    chk("locked_before_rst", 32'(locked), 1);

    // Asynchronous reset mid-LOCKED with hb_in held high through release.
    #2;
    nreset = 1'b0;
    hb_in = 1'b1;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("in_rst");
    r = cyc;
    n_beats = 0;
    n_errs = 0;
    exp_beat(r, S_ACQ, 0, 0, 0, "rel");
    push(r + 8, SEL_STATE, int'(S_ACQ), "rel_single_state");
    push(r + 8, SEL_BEATS, exp_stat(1), "rel_single_beats");
    nreset = 1'b1;
    wait_until(r + 6);
    hb_in = 1'b0;
    wait_until(r + 10);

    chk("sb_drain", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
